// File: rtl/seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg_scan_ctrl
//   Time-multiplexed scan controller for a DIGITS-wide common-segment
//   7-segment display. A packed BCD word is held in a shadow register and
//   shown one digit per scan slot. Each slot lasts SCAN_DIV clk cycles.
//   The active nibble is decoded onto a shared segment bus. A load/busy
//   handshake lets new values enter the shadow register only at a frame
//   boundary, so one frame never shows a mix of old and new digits.
//
//   Optional feature (compile-time macro LEADING_ZERO_BLANK_EN):
//     A zero digit is blanked when every more-significant digit is also
//     zero. Digit 0 is never blanked. When the macro is not defined, every
//     digit is decoded literally.
//
// Parameters
//   DIGITS      number of scanned digits, 1..8
//   SCAN_DIV    clk cycles per digit slot, >= 2
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous reset, active-low
//   en          1 = scanning; 0 = display blanked, divider and index hold
//   load        1-cycle strobe, captures bcd_in into the pending buffer
//   bcd_in      packed BCD, [3:0] = digit 0 (least significant)
//   busy        a pending value has not yet reached the display
//   dig_sel     one-hot digit enable, active-high, bit0 = digit 0
//   codeout     segment pattern g..a, active-high
//   frame_done  1-cycle pulse when the digit index wraps to 0
// ---------------------------------------------------------------------------
module seg_scan_ctrl #(
    parameter int DIGITS   = 4,
    parameter int SCAN_DIV = 50000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   bcd_in,
    output logic                  busy,
    output logic [DIGITS-1:0]     dig_sel,
    output logic [6:0]            codeout,
    output logic                  frame_done
);

    localparam int DIV_W = $clog2(SCAN_DIV);
    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);

    // Segment encoding, bit6..bit0 = g..a
    function automatic logic [6:0] seg_decode(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'd0:    seg = 7'b0111111;
            4'd1:    seg = 7'b0000110;
            4'd2:    seg = 7'b1011011;
            4'd3:    seg = 7'b1001111;
            4'd4:    seg = 7'b1100110;
            4'd5:    seg = 7'b1101101;
            4'd6:    seg = 7'b1111101;
            4'd7:    seg = 7'b0000111;
            4'd8:    seg = 7'b1111111;
            4'd9:    seg = 7'b1101111;
            default: seg = 7'b0000000;   // non-BCD nibbles stay dark
        endcase
        return seg;
    endfunction

    // State registers
    logic [DIV_W-1:0]    div_cnt_q, div_cnt_d;
    logic [IDX_W-1:0]    idx_q,     idx_d;
    logic [4*DIGITS-1:0] shadow_q,  shadow_d;
    logic [4*DIGITS-1:0] pending_q, pending_d;
    logic                busy_q,    busy_d;

    // Registered outputs
    logic [DIGITS-1:0]   dig_sel_q,    dig_sel_d;
    logic [6:0]          codeout_q,    codeout_d;
    logic                frame_done_q, frame_done_d;

    // Internal combinational signals
    logic                div_tc;
    logic                frame_wrap;
    logic                commit;
    logic [3:0]          cur_nib;
    logic [6:0]          seg_show;

    // -----------------------------------------------------------------------
    // Slot divider and digit index
    // -----------------------------------------------------------------------
    always_comb begin
        div_tc     = (div_cnt_q == DIV_LAST);
        frame_wrap = en && div_tc && (idx_q == IDX_LAST);
        div_cnt_d  = div_cnt_q;
        idx_d      = idx_q;
        if (en) begin
            if (div_tc) begin
                div_cnt_d = '0;
                idx_d     = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
            end else begin
                div_cnt_d = div_cnt_q + 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Load / commit handshake
    //   When the display is blanked (en=0), nothing is visible that could
    //   tear, so a pending value is committed on the next cycle. If a load
    //   arrives in the same cycle as a commit, the shadow register takes the
    //   old pending value and busy stays set for the new one.
    // -----------------------------------------------------------------------
    always_comb begin
        commit    = busy_q && (frame_wrap || !en);
        shadow_d  = commit ? pending_q : shadow_q;
        pending_d = load ? bcd_in : pending_q;
        if (load) begin
            busy_d = 1'b1;
        end else if (commit) begin
            busy_d = 1'b0;
        end else begin
            busy_d = busy_q;
        end
    end

    // -----------------------------------------------------------------------
    // Active digit select and segment decode
    // -----------------------------------------------------------------------
    always_comb begin
        cur_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_q == IDX_W'(i)) begin
                cur_nib = shadow_q[4*i +: 4];
            end
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic upper_zero;

    // Check whether every digit above the active one is zero.
    always_comb begin
        upper_zero = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if ((int'(idx_q) < i) && (shadow_q[4*i +: 4] != 4'd0)) begin
                upper_zero = 1'b0;
            end
        end
    end

    always_comb begin
        if ((idx_q != '0) && (cur_nib == 4'd0) && upper_zero) begin
            seg_show = 7'b0000000;
        end else begin
            seg_show = seg_decode(cur_nib);
        end
    end
`else
    always_comb begin
        seg_show = seg_decode(cur_nib);
    end
`endif

    always_comb begin
        dig_sel_d    = en ? (DIGITS'(1) << idx_q) : '0;
        codeout_d    = en ? seg_show : 7'b0000000;
        frame_done_d = frame_wrap;
    end

    // -----------------------------------------------------------------------
    // Registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_cnt_q    <= '0;
            idx_q        <= '0;
            shadow_q     <= '0;
            pending_q    <= '0;
            busy_q       <= 1'b0;
            dig_sel_q    <= '0;
            codeout_q    <= 7'b0000000;
            frame_done_q <= 1'b0;
        end else begin
            div_cnt_q    <= div_cnt_d;
            idx_q        <= idx_d;
            shadow_q     <= shadow_d;
            pending_q    <= pending_d;
            busy_q       <= busy_d;
            dig_sel_q    <= dig_sel_d;
            codeout_q    <= codeout_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign busy       = busy_q;
    assign dig_sel    = dig_sel_q;
    assign codeout    = codeout_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg_scan_ctrl
//   Directed bench for seg_scan_ctrl with DIGITS=4 and SCAN_DIV=4.
//   A vector table holds BCD words and their expected per-digit segments.
//   Hand-written sequences cover reset, the en pause, and the load/commit
//   corner cases.
// ---------------------------------------------------------------------------
module tb_seg_scan_ctrl;

    localparam int DIGITS   = 4;
    localparam int SCAN_DIV = 4;

    localparam logic [6:0] S0 = 7'b0111111;
    localparam logic [6:0] S1 = 7'b0000110;
    localparam logic [6:0] S2 = 7'b1011011;
    localparam logic [6:0] S3 = 7'b1001111;
    localparam logic [6:0] S4 = 7'b1100110;
    localparam logic [6:0] S5 = 7'b1101101;
    localparam logic [6:0] S6 = 7'b1111101;
    localparam logic [6:0] S7 = 7'b0000111;
    localparam logic [6:0] S8 = 7'b1111111;
    localparam logic [6:0] S9 = 7'b1101111;
    localparam logic [6:0] BL = 7'b0000000;
`ifdef LEADING_ZERO_BLANK_EN
    localparam logic [6:0] ZB = 7'b0000000;
`else
    localparam logic [6:0] ZB = 7'b0111111;
`endif

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en;
    logic                load;
    logic [4*DIGITS-1:0] bcd_in;
    logic                busy;
    logic [DIGITS-1:0]   dig_sel;
    logic [6:0]          codeout;
    logic                frame_done;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    seg_scan_ctrl #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .load       (load),
        .bcd_in     (bcd_in),
        .busy       (busy),
        .dig_sel    (dig_sel),
        .codeout    (codeout),
        .frame_done (frame_done)
    );

    // segs holds the expected codes as {digit3, digit2, digit1, digit0}
    typedef struct {
        logic [15:0] bcd;
        logic [27:0] segs;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_busy_low(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy === 1'b0) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_dig(input logic [3:0] want, input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (dig_sel === want) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    task automatic wait_frame(input string name);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (frame_done === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        chk(name, 32'(ok), 32'd1);
    endtask

    initial begin
        vecs[0] = '{bcd: 16'h1234, segs: {S1, S2, S3, S4}};
        vecs[1] = '{bcd: 16'h00A5, segs: {ZB, ZB, BL, S5}};
        vecs[2] = '{bcd: 16'h0070, segs: {ZB, ZB, S7, S0}};
        vecs[3] = '{bcd: 16'h9876, segs: {S9, S8, S7, S6}};
        vecs[4] = '{bcd: 16'hF0F0, segs: {BL, S0, BL, S0}};
        vecs[5] = '{bcd: 16'h0000, segs: {ZB, ZB, ZB, S0}};
        vecs[6] = '{bcd: 16'h0301, segs: {ZB, S3, S0, S1}};

        rst_n  = 1'b0;
        en     = 1'b0;
        load   = 1'b0;
        bcd_in = '0;

        // Power-on reset
        tick(3);
        chk("rst_busy",    32'(busy),       32'd0);
        chk("rst_dig_sel", 32'(dig_sel),    32'd0);
        chk("rst_codeout", 32'(codeout),    32'd0);
        chk("rst_frame",   32'(frame_done), 32'd0);

        rst_n = 1'b1;
        en    = 1'b1;
        tick(2);

        // Vector table: load, wait for commit, then check each digit slot
        for (int v = 0; v < 7; v++) begin
            logic [3:0] ds;
            load   = 1'b1;
            bcd_in = vecs[v].bcd;
            tick(1);
            load = 1'b0;
            chk($sformatf("v%0d_busy_set", v), 32'(busy), 32'd1);
            wait_busy_low($sformatf("v%0d_commit_timeout", v));
            chk($sformatf("v%0d_frame_done", v), 32'(frame_done), 32'd1);
            tick(1);
            for (int k = 0; k < 4; k++) begin
                ds = 4'b0001 << k;
                chk($sformatf("v%0d_d%0d_sel", v, k), 32'(dig_sel), 32'(ds));
                chk($sformatf("v%0d_d%0d_seg", v, k), 32'(codeout), 32'(vecs[v].segs[7*k +: 7]));
                tick(4);
            end
        end

        // Pause scanning at digit 2, then resume from the same point
        load   = 1'b1;
        bcd_in = 16'h1234;
        tick(1);
        load = 1'b0;
        wait_busy_low("pause_commit_timeout");
        wait_dig(4'b0100, "pause_wait_idx2");
        en = 1'b0;
        tick(1);
        chk("pause_sel_blank", 32'(dig_sel), 32'd0);
        chk("pause_seg_blank", 32'(codeout), 32'd0);
        tick(5);
        chk("pause_sel_hold",  32'(dig_sel),    32'd0);
        chk("pause_no_frame",  32'(frame_done), 32'd0);
        en = 1'b1;
        tick(1);
        chk("resume_sel", 32'(dig_sel), 32'b0100);
        chk("resume_seg", 32'(codeout), 32'(S2));
        tick(2);
        chk("resume_div_held", 32'(dig_sel), 32'b0100);
        tick(1);
        chk("resume_next_sel", 32'(dig_sel), 32'b1000);
        chk("resume_next_seg", 32'(codeout), 32'(S1));

        // With the display blanked, a load commits on the next cycle
        en = 1'b0;
        tick(1);
        load   = 1'b1;
        bcd_in = 16'h0301;
        tick(1);
        load = 1'b0;
        chk("en0_busy_set",    32'(busy),       32'd1);
        tick(1);
        chk("en0_busy_clear",  32'(busy),       32'd0);
        chk("en0_no_frame",    32'(frame_done), 32'd0);
        chk("en0_sel_blank",   32'(dig_sel),    32'd0);
        en = 1'b1;
        wait_dig(4'b0001, "en0_wait_d0");
        chk("en0_d0_seg", 32'(codeout), 32'(S1));
        tick(4);
        chk("en0_d1_sel", 32'(dig_sel), 32'b0010);
        chk("en0_d1_seg", 32'(codeout), 32'(S0));

        // Load on the same edge as a commit
        wait_frame("coin_wait_frame");
        load   = 1'b1;
        bcd_in = 16'h1234;
        tick(1);
        load = 1'b0;
        tick(14);
        load   = 1'b1;
        bcd_in = 16'h9876;
        tick(1);
        load = 1'b0;
        chk("coin_frame_done", 32'(frame_done), 32'd1);
        chk("coin_busy_kept",  32'(busy),       32'd1);
        tick(1);
        chk("coin_old_sel", 32'(dig_sel), 32'b0001);
        chk("coin_old_seg", 32'(codeout), 32'(S4));
        wait_busy_low("coin_commit_timeout");
        chk("coin_frame2", 32'(frame_done), 32'd1);
        tick(1);
        chk("coin_new_sel", 32'(dig_sel), 32'b0001);
        chk("coin_new_seg", 32'(codeout), 32'(S6));

        // Two loads in one frame: only the last one is committed
        begin
            int   falls;
            int   bad;
            int   good;
            logic prev;
            load   = 1'b1;
            bcd_in = 16'h1111;
            tick(1);
            load = 1'b0;
            tick(2);
            load   = 1'b1;
            bcd_in = 16'h2222;
            tick(1);
            load = 1'b0;
            chk("coal_busy", 32'(busy), 32'd1);
            falls = 0;
            bad   = 0;
            good  = 0;
            prev  = busy;
            for (int i = 0; i < 40; i++) begin
                tick(1);
                if (prev && !busy) falls++;
                if (codeout === S1) bad++;
                if (codeout === S2) good++;
                prev = busy;
            end
            chk("coal_commits",   32'(falls),     32'd1);
            chk("coal_old_shown", 32'(bad),       32'd0);
            chk("coal_new_shown", 32'(good != 0), 32'd1);
        end

        // Reset in the middle of a scan with a value still pending
        load   = 1'b1;
        bcd_in = 16'h1111;
        tick(1);
        load = 1'b0;
        tick(2);
        rst_n = 1'b0;
        tick(3);
        chk("mrst_busy",    32'(busy),       32'd0);
        chk("mrst_dig_sel", 32'(dig_sel),    32'd0);
        chk("mrst_codeout", 32'(codeout),    32'd0);
        chk("mrst_frame",   32'(frame_done), 32'd0);
        rst_n = 1'b1;
        tick(1);
        chk("mrst_d0_sel", 32'(dig_sel), 32'b0001);
        chk("mrst_d0_seg", 32'(codeout), 32'(S0));
        tick(4);
        chk("mrst_d1_sel", 32'(dig_sel), 32'b0010);
        chk("mrst_d1_seg", 32'(codeout), 32'(ZB));
        chk("mrst_busy2",  32'(busy),    32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
